// File: rtl/fuel_gauge_ctrl_if.sv
// Signal bundle between the fuel gauge sequencing controller and its environment.
// The controller owns the slave side; stimulus or a host drives the master side.
interface fuel_gauge_ctrl_if;
   logic       sample_tick_in;
   logic [3:0] raw_lvl_in;
   logic       blank_req_in;
   logic [3:0] flvl_out;
   logic       bmode_out;
   logic       low_fuel_out;
   logic       ready_out;
   logic [1:0] state_out;

   modport master (
      output sample_tick_in,
      output raw_lvl_in,
      output blank_req_in,
      input  flvl_out,
      input  bmode_out,
      input  low_fuel_out,
      input  ready_out,
      input  state_out
   );

   modport slave (
      input  sample_tick_in,
      input  raw_lvl_in,
      input  blank_req_in,
      output flvl_out,
      output bmode_out,
      output low_fuel_out,
      output ready_out,
      output state_out
   );
endinterface

// File: rtl/fuel_gauge_ctrl.sv
// Fuel gauge sequencing controller: 4-sample moving average of the sensor, low-fuel
// FSM with hysteresis and a blink generator driving the gauge blank-mode input.
module fuel_gauge_ctrl #(
   parameter int unsigned LOW_THRESH = 2,
   parameter int unsigned HYST       = 2,
   parameter int unsigned BLINK_DIV  = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   fuel_gauge_ctrl_if.slave   fg
);

   typedef enum logic [1:0] {
      StStartup = 2'b00,
      StNormal  = 2'b01,
      StLow     = 2'b10
   } state_e;

   localparam logic [3:0]       LoThresh = 4'(LOW_THRESH);
   localparam logic [3:0]       HiThresh = 4'(LOW_THRESH + HYST);
   localparam logic [CNT_W-1:0] BlinkMax = CNT_W'(BLINK_DIV - 1);

   state_e           state_q, state_d;
   logic [3:0]       win_q [4];
   logic [3:0]       win_d [4];
   logic [2:0]       fill_q, fill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic [3:0]       flvl_q, flvl_d;
   logic             bmode_q, bmode_d;
   logic             low_fuel_q, low_fuel_d;
   logic             ready_q, ready_d;

   logic [5:0]       avg_sum;
   logic [3:0]       avg_new;

   // Sum of the window as it will look after this tick shifts in.
   assign avg_sum = 6'(fg.raw_lvl_in) + 6'(win_q[0]) + 6'(win_q[1]) + 6'(win_q[2]);
   assign avg_new = avg_sum[5:2];

   always_comb begin
      win_d      = win_q;
      fill_d     = fill_q;
      flvl_d     = flvl_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      bmode_d    = bmode_q;

      if (fg.sample_tick_in) begin
         win_d[0] = fg.raw_lvl_in;
         win_d[1] = win_q[0];
         win_d[2] = win_q[1];
         win_d[3] = win_q[2];
         flvl_d   = avg_new;
         if (fill_q != 3'd4) begin
            fill_d = fill_q + 3'd1;
         end

         case (state_q)
            StStartup: begin
               if (fill_q == 3'd3) begin
                  state_d = (avg_new <= LoThresh) ? StLow : StNormal;
               end
            end
            StNormal: begin
               if (avg_new <= LoThresh) begin
                  state_d = StLow;
               end
            end
            StLow: begin
               if (avg_new >= HiThresh) begin
                  state_d = StNormal;
               end
            end
            default: state_d = StStartup;
         endcase
      end

      // Blink runs only while staying in LOW; entering or leaving clears it.
      if (state_q == StLow && state_d == StLow) begin
         if (cnt_q == BlinkMax) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end

      if (fg.blank_req_in) begin
         bmode_d = 1'b1;
      end else begin
         case (state_d)
            StStartup: bmode_d = 1'b1;
            StNormal:  bmode_d = 1'b0;
            StLow:     bmode_d = phase_d;
            default:   bmode_d = 1'b1;
         endcase
      end

      ready_d    = (fill_d == 3'd4);
      low_fuel_d = (state_d == StLow);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= StStartup;
         win_q[0]   <= '0;
         win_q[1]   <= '0;
         win_q[2]   <= '0;
         win_q[3]   <= '0;
         fill_q     <= '0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         flvl_q     <= '0;
         bmode_q    <= 1'b1;
         low_fuel_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q[0]   <= win_d[0];
         win_q[1]   <= win_d[1];
         win_q[2]   <= win_d[2];
         win_q[3]   <= win_d[3];
         fill_q     <= fill_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         flvl_q     <= flvl_d;
         bmode_q    <= bmode_d;
         low_fuel_q <= low_fuel_d;
         ready_q    <= ready_d;
      end
   end

   assign fg.flvl_out     = flvl_q;
   assign fg.bmode_out    = bmode_q;
   assign fg.low_fuel_out = low_fuel_q;
   assign fg.ready_out    = ready_q;
   assign fg.state_out    = state_q;

endmodule
